// File: rtl/inv_sub_bytes_seq.sv
// Iterative AES InvSubBytes engine: one 128-bit state in, LANES inverse S-boxes per cycle,
// result held on a valid/ready output until taken.
module inv_sub_bytes_seq #(
  parameter int unsigned LANES = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [127:0] i_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [127:0] o_data,
  output logic         o_busy
);

  localparam int unsigned K    = 16 / LANES;
  localparam int unsigned CntW = (K > 1) ? $clog2(K) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(K - 1);

  if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
    $error("inv_sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
  end

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } state_e;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = xtime(t);
    end
    return p;
  endfunction

  // x^254 == x^-1 in GF(2^8); also maps 0 to 0 without a special case.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] sq;
    r  = 8'h01;
    sq = x;
    for (int i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] inv_affine(input logic [7:0] x);
    logic [7:0] y;
    for (int i = 0; i < 8; i++) begin
      y[i] = x[(i + 2) % 8] ^ x[(i + 5) % 8] ^ x[(i + 7) % 8];
    end
    return y ^ 8'h05;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return gf_inv(inv_affine(x));
  endfunction

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [127:0]    work_q, work_d;
  logic [127:0]    out_q, out_d;
  logic [127:0]    work_sub;

  // Replace the current chunk of LANES bytes in place; byte 0 sits in the top bits.
  always_comb begin
    work_sub = work_q;
    for (int l = 0; l < int'(LANES); l++) begin
      work_sub[127 - 8 * (int'(cnt_q) * int'(LANES) + l) -: 8] =
          inv_sbox(work_q[127 - 8 * (int'(cnt_q) * int'(LANES) + l) -: 8]);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    out_d   = out_q;
    unique case (state_q)
      StIdle: begin
        if (i_valid) begin
          work_d  = i_data;
          cnt_d   = '0;
          state_d = StBusy;
        end
      end
      StBusy: begin
        work_d = work_sub;
        if (cnt_q == CntLast) begin
          cnt_d   = '0;
          out_d   = work_sub;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        if (i_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      work_q  <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      out_q   <= out_d;
    end
  end

  // out_q only loads on entry to DONE, so o_data keeps its last value elsewhere.
  assign o_ready = (state_q == StIdle);
  assign o_valid = (state_q == StDone);
  assign o_busy  = (state_q != StIdle);
  assign o_data  = out_q;

endmodule
